// File: rtl/parking_request_fifo_pkg.sv
// Shared constants and request record for the parking-lot request intake.
package parking_request_fifo_pkg;

  localparam int         PLATE_W    = 16;
  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  localparam logic       DIR_IN     = 1'b1;
  localparam logic       DIR_OUT    = 1'b0;
  localparam logic       TYPE_SUV   = 1'b1;
  localparam logic       TYPE_SEDAN = 1'b0;

  typedef struct packed {
    logic [PLATE_W-1:0] plate;
    logic               dir;
    logic               plate_type;
  } req_t;

endpackage

// File: rtl/parking_request_fifo_if.sv
// Consumer-side valid/ready handshake carrying the head request.
interface parking_request_fifo_if #(
  parameter int PLATE_W = parking_request_fifo_pkg::PLATE_W
);
  logic               req_valid;
  logic               req_ready;
  logic [PLATE_W-1:0] req_plate;
  logic               req_dir;
  logic               req_type;

  modport master (
    output req_valid, req_plate, req_dir, req_type,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_plate, req_dir, req_type,
    output req_ready
  );
endinterface

// File: rtl/parking_request_fifo_plate_check.sv
// Combinational plate validator (all digits BCD, plate nonzero) and SUV/sedan classifier.
module parking_request_fifo_plate_check
  import parking_request_fifo_pkg::*;
#(
  parameter int PLATE_W = parking_request_fifo_pkg::PLATE_W
) (
  input  logic [PLATE_W-1:0] plate,
  output logic               plate_ok,
  output logic               plate_type
);

  // A plate is usable when nonzero and every nibble is a decimal digit
  always_comb begin
    plate_ok = (plate != '0);
    for (int i = 0; i < PLATE_W / 4; i++) begin
      if (plate[i*4 +: 4] > DIGIT_MAX) plate_ok = 1'b0;
    end
  end

  // Odd last digit means SUV; the LSB of the low BCD digit carries parity
  assign plate_type = plate[0] ? TYPE_SUV : TYPE_SEDAN;

endmodule

// File: rtl/parking_request_fifo.sv
// Intake FIFO for parking requests: validates entry/exit strobes, buffers them
// in a first-word-fall-through circular buffer and hands them to the elevator
// controller over a valid/ready handshake.
module parking_request_fifo
  import parking_request_fifo_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PLATE_W = parking_request_fifo_pkg::PLATE_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [PLATE_W-1:0]         license_plate,
  input  logic                       in_mode,
  input  logic                       out_mode,
  input  logic                       flush,
  parking_request_fifo_if.master     req_bus,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       reject,
  output logic [7:0]                 drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PLATE_W + 2;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  logic          plate_ok;
  logic          plate_type;
  logic          strobe;
  logic          push_req;
  logic          pop;
  logic          accept;
  logic          discard;
  logic          not_empty;
  logic [EW-1:0] head;

  parking_request_fifo_plate_check #(.PLATE_W(PLATE_W)) u_plate_check (
    .plate      (license_plate),
    .plate_ok   (plate_ok),
    .plate_type (plate_type)
  );

  assign strobe    = in_mode | out_mode;
  assign push_req  = in_mode ^ out_mode;
  assign not_empty = (cnt != '0);
  assign full      = (cnt == CW'(DEPTH));
  assign pop       = not_empty & req_bus.req_ready & ~flush;
  // A full FIFO still takes a push when the head leaves on the same edge
  assign accept    = push_req & plate_ok & (~full | pop) & ~flush;
  // Flush swallows any same-cycle strobe silently
  assign discard   = strobe & ~accept & ~flush;

  assign head              = mem[rd_ptr];
  assign count             = cnt;
  assign req_bus.req_valid = not_empty;
  assign req_bus.req_plate = not_empty ? head[EW-1:2] : '0;
  assign req_bus.req_dir   = not_empty ? head[1]      : 1'b0;
  assign req_bus.req_type  = not_empty ? head[0]      : 1'b0;

  // Request storage: data only, no reset; visibility is governed by count
  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr] <= {license_plate, (in_mode ? DIR_IN : DIR_OUT), plate_type};
  end

  // Pointers and occupancy; flush overrides push and pop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(accept) - CW'(pop);
    end
  end

  // Reject pulse and saturating drop counter; drop_cnt survives flush
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reject   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      reject <= discard;
      if (discard && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_parking_request_fifo.sv
// Directed bench for parking_request_fifo: vector table plus flush, reset and saturation sequences.
module tb_parking_request_fifo;
  import parking_request_fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] plate;
  logic        in_m, out_m, flush;
  logic [2:0]  count;
  logic        full, reject;
  logic [7:0]  drop_cnt;
  int          checks = 0;
  int          errors = 0;

  parking_request_fifo_if #(.PLATE_W(16)) bus ();

  parking_request_fifo #(.DEPTH(4), .PLATE_W(16)) dut (
    .clock         (clk),
    .reset         (rst_n),
    .license_plate (plate),
    .in_mode       (in_m),
    .out_mode      (out_m),
    .flush         (flush),
    .req_bus       (bus.master),
    .count         (count),
    .full          (full),
    .reject        (reject),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] plate;
    logic        in_m, out_m, rdy;
    logic        ev;
    logic [15:0] ep;
    logic        ed, et;
    int          ec;
    logic        ef, er;
    int          edrop;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic [15:0] p, logic i, logic o, logic r, logic ev, logic [15:0] ep,
                              logic ed, logic et, int ec, logic ef, logic er, int edrop);
    vec_t v;
    v.plate = p; v.in_m = i; v.out_m = o; v.rdy = r;
    v.ev = ev; v.ep = ep; v.ed = ed; v.et = et; v.ec = ec; v.ef = ef; v.er = er; v.edrop = edrop;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] p, input logic i, input logic o, input logic r, input logic f);
    plate = p; in_m = i; out_m = o; bus.req_ready = r; flush = f;
  endtask

  initial begin
    drive(16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    // plate, in, out, rdy | valid, plate, dir, type, count, full, reject, drop
    vecs[0]  = mk(16'h8754, 1, 0, 0, 1, 16'h8754, 1, 0, 1, 0, 0, 0);
    vecs[1]  = mk(16'h9423, 1, 0, 0, 1, 16'h8754, 1, 0, 2, 0, 0, 0);
    vecs[2]  = mk(16'h8754, 0, 1, 0, 1, 16'h8754, 1, 0, 3, 0, 0, 0);
    vecs[3]  = mk(16'h0000, 0, 0, 1, 1, 16'h9423, 1, 1, 2, 0, 0, 0);
    vecs[4]  = mk(16'h0000, 0, 0, 1, 1, 16'h8754, 0, 0, 1, 0, 0, 0);
    vecs[5]  = mk(16'h0000, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(16'h0000, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(16'h1111, 1, 0, 0, 1, 16'h1111, 1, 1, 1, 0, 0, 0);
    vecs[8]  = mk(16'h2222, 0, 1, 0, 1, 16'h1111, 1, 1, 2, 0, 0, 0);
    vecs[9]  = mk(16'h3333, 1, 0, 0, 1, 16'h1111, 1, 1, 3, 0, 0, 0);
    vecs[10] = mk(16'h4444, 1, 0, 0, 1, 16'h1111, 1, 1, 4, 1, 0, 0);
    vecs[11] = mk(16'h5555, 1, 0, 0, 1, 16'h1111, 1, 1, 4, 1, 1, 1);
    vecs[12] = mk(16'h0000, 0, 0, 0, 1, 16'h1111, 1, 1, 4, 1, 0, 1);
    vecs[13] = mk(16'h1234, 1, 0, 1, 1, 16'h2222, 0, 0, 4, 1, 0, 1);
    vecs[14] = mk(16'h0000, 0, 0, 1, 1, 16'h3333, 1, 1, 3, 0, 0, 1);
    vecs[15] = mk(16'h0000, 0, 0, 1, 1, 16'h4444, 1, 0, 2, 0, 0, 1);
    vecs[16] = mk(16'h0000, 0, 0, 1, 1, 16'h1234, 1, 0, 1, 0, 0, 1);
    vecs[17] = mk(16'h0000, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 1);
    vecs[18] = mk(16'h8A54, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 2);
    vecs[19] = mk(16'h8754, 1, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 3);
    vecs[20] = mk(16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 4);
    vecs[21] = mk(16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 4);
    vecs[22] = mk(16'h5678, 1, 0, 1, 1, 16'h5678, 1, 0, 1, 0, 0, 4);
    vecs[23] = mk(16'h0000, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 4);

    repeat (2) step();
    chk("rst_valid", 32'(bus.req_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_reject", 32'(reject), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_plate", 32'(bus.req_plate), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].plate, vecs[i].in_m, vecs[i].out_m, vecs[i].rdy, 1'b0);
      step();
      chk($sformatf("v%0d_valid", i), 32'(bus.req_valid), 32'(vecs[i].ev));
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_plate", i), 32'(bus.req_plate), 32'(vecs[i].ep));
        chk($sformatf("v%0d_dir", i), 32'(bus.req_dir), 32'(vecs[i].ed));
        chk($sformatf("v%0d_type", i), 32'(bus.req_type), 32'(vecs[i].et));
      end
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].ec));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].ef));
      chk($sformatf("v%0d_reject", i), 32'(reject), 32'(vecs[i].er));
      chk($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(vecs[i].edrop));
    end

    // Flush with a same-cycle valid push: queue cleared, no reject, drop_cnt kept
    drive(16'h1357, 1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(16'h2468, 1'b0, 1'b1, 1'b0, 1'b0); step();
    drive(16'h9999, 1'b1, 1'b0, 1'b0, 1'b0); step();
    chk("fl_pre_count", 32'(count), 32'd3);
    drive(16'h1111, 1'b1, 1'b0, 1'b1, 1'b1); step();
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_valid", 32'(bus.req_valid), 32'd0);
    chk("fl_reject", 32'(reject), 32'd0);
    chk("fl_drop", 32'(drop_cnt), 32'd4);
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0); step();
    chk("fl_after_count", 32'(count), 32'd0);

    // Asynchronous reset in the middle of traffic with a live reject pulse
    drive(16'h1111, 1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ar_pre_reject", 32'(reject), 32'd1);
    chk("ar_pre_count", 32'(count), 32'd1);
    chk("ar_pre_drop", 32'(drop_cnt), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.req_valid), 32'd0);
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_reject", 32'(reject), 32'd0);
    chk("ar_drop", 32'(drop_cnt), 32'd0);
    chk("ar_plate", 32'(bus.req_plate), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // drop_cnt saturates at 255
    for (int i = 0; i < 260; i++) begin
      drive(16'h8754, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    chk("sat_drop", 32'(drop_cnt), 32'd255);
    chk("sat_reject", 32'(reject), 32'd1);
    chk("sat_count", 32'(count), 32'd0);
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0); step();
    chk("sat_hold", 32'(drop_cnt), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
